// File: rtl/pcie_phy_pkg.sv
// Shared types and constants for the PCIe PHY transmit path.
// The optional running-disparity checker is enabled with TX_SER_DISP_CHECK_EN.
package pcie_phy_pkg;

   localparam int SYM_W = 10;

   typedef logic [SYM_W-1:0] sym10_t;

   typedef enum logic {
      SER_IDLE,
      SER_SHIFT
   } ser_state_e;

   // Counter value at which the last bit ('j') of a symbol is on the wire
   localparam logic [3:0] LAST_BIT = 4'd9;

   // Population count of a 10-bit symbol; result range 0..10
   function automatic logic [3:0] count_ones(input sym10_t sym);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < SYM_W; i++) begin
         n = n + {3'b000, sym[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/disparity_checker_10b.sv
// Running-disparity checker for 8b/10b symbols entering the serializer.
// Compiled only when TX_SER_DISP_CHECK_EN is defined; otherwise no checker exists.
`ifdef TX_SER_DISP_CHECK_EN
module disparity_checker_10b (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   load_i,
   input  pcie_phy_pkg::sym10_t sym_i,
   output logic   err_o
);
   import pcie_phy_pkg::*;

   logic       rd_pos_q;
   logic       rd_pos_d;
   logic       sym_err;
   logic [3:0] ones;

   // Classify the symbol being loaded and work out the disparity it leaves behind
   always_comb begin
      ones     = count_ones(sym_i);
      sym_err  = 1'b0;
      rd_pos_d = rd_pos_q;
      if (ones == 4'd6) begin
         sym_err  = rd_pos_q;
         rd_pos_d = 1'b1;
      end else if (ones == 4'd4) begin
         sym_err  = !rd_pos_q;
         rd_pos_d = 1'b0;
      end else if (ones != 4'd5) begin
         sym_err  = 1'b1;
      end
   end

   // Track running disparity and pulse the error during the symbol's first bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_pos_q <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         err_o <= load_i && sym_err;
         if (load_i) begin
            rd_pos_q <= rd_pos_d;
         end
      end
   end

endmodule
`endif

// File: rtl/tx_serializer_10b.sv
// 10-bit symbol serializer with a one-deep holding register for gapless streaming.
// Define TX_SER_DISP_CHECK_EN to add the running-disparity checker on disp_err_o.
module tx_serializer_10b #(
   parameter int SYM_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sym_valid_i,
   input  logic [SYM_W-1:0] sym_i,
   output logic             sym_ready_o,
   output logic             ser_o,
   output logic             ser_valid_o,
   output logic             underrun_o,
   output logic             disp_err_o
);
   import pcie_phy_pkg::*;

   ser_state_e state_q;
   ser_state_e state_d;

   sym10_t     shift_q;
   sym10_t     hold_q;
   logic       hold_valid_q;
   logic       hold_valid_d;
   logic       ready_q;
   logic [3:0] bit_cnt_q;
   logic       underrun_q;

   logic       xfer;
   logic       last_bit;
   logic       hold_write;
   logic       load_shift;
   sym10_t     load_value;

   assign xfer     = sym_valid_i && ready_q;
   assign last_bit = (state_q == SER_SHIFT) && (bit_cnt_q == LAST_BIT);

   // Decide when the shift register takes a new symbol and where it comes from
   always_comb begin
      hold_write   = (state_q == SER_SHIFT) && (bit_cnt_q != LAST_BIT) && xfer;
      load_shift   = ((state_q == SER_IDLE) && xfer) ||
                     (last_bit && (hold_valid_q || xfer));
      load_value   = hold_valid_q ? hold_q : sym_i;
      hold_valid_d = hold_valid_q;
      if (hold_write) begin
         hold_valid_d = 1'b1;
      end else if (last_bit && hold_valid_q) begin
         hold_valid_d = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SER_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: leave IDLE on a transfer, drop back when the stream runs dry
   always_comb begin
      state_d = state_q;
      case (state_q)
         SER_IDLE: begin
            if (xfer) begin
               state_d = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            if (last_bit && !hold_valid_q && !xfer) begin
               state_d = SER_IDLE;
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   // FSM outputs: the serial line is quiet in IDLE and carries shift[0] in SHIFT
   always_comb begin
      ser_o       = 1'b0;
      ser_valid_o = 1'b0;
      if (state_q == SER_SHIFT) begin
         ser_o       = shift_q[0];
         ser_valid_o = 1'b1;
      end
   end

   // Shift register and bit counter: reload on a new symbol, otherwise shift out LSB first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (load_shift) begin
         shift_q   <= load_value;
         bit_cnt_q <= '0;
      end else if (state_q == SER_SHIFT) begin
         shift_q   <= {1'b0, shift_q[SYM_W-1:1]};
         bit_cnt_q <= bit_cnt_q + 4'd1;
      end
   end

   // Holding register; ready is kept as its own flop mirroring an empty hold slot
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         if (hold_write) begin
            hold_q <= sym_i;
         end
         hold_valid_q <= hold_valid_d;
         ready_q      <= !hold_valid_d;
      end
   end

   // Underrun pulse for the first IDLE cycle after the last bit went out
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= (state_q == SER_SHIFT) && (state_d == SER_IDLE);
      end
   end

   assign sym_ready_o = ready_q;
   assign underrun_o  = underrun_q;

`ifdef TX_SER_DISP_CHECK_EN
   disparity_checker_10b u_disp_check (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load_shift),
      .sym_i  (load_value),
      .err_o  (disp_err_o)
   );
`else
   assign disp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Bench for tx_serializer_10b: directed scenarios plus random traffic with resets,
// compared cycle by cycle against a queue-based transaction model.
module tb_tx_serializer_10b;
   import pcie_phy_pkg::*;

   logic   clk_i = 1'b0;
   logic   rst_i = 1'b1;
   logic   sym_valid_i = 1'b0;
   sym10_t sym_i = '0;
   logic   sym_ready_o;
   logic   ser_o;
   logic   ser_valid_o;
   logic   underrun_o;
   logic   disp_err_o;

   int     checkCount = 0;
   int     failCount  = 0;

   // Model state: bits of the symbol on the wire, symbols waiting behind it
   bit     curBits[$];
   sym10_t waitQ[$];
   bit     expUnderrun = 1'b0;
   bit     expDisp = 1'b0;
   bit     rdPos = 1'b0;

   tx_serializer_10b #(.SYM_W(10)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sym_valid_i (sym_valid_i),
      .sym_i       (sym_i),
      .sym_ready_o (sym_ready_o),
      .ser_o       (ser_o),
      .ser_valid_o (ser_valid_o),
      .underrun_o  (underrun_o),
      .disp_err_o  (disp_err_o)
   );

   // Free-running clock, 10 time units per period
   always #5 clk_i = ~clk_i;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // A symbol starts on the wire: queue its bits a-first and judge its disparity
   task automatic loadSym(input sym10_t s);
      int ones;
      for (int i = 0; i < 10; i++) curBits.push_back(s[i]);
      ones = $countones(s);
`ifdef TX_SER_DISP_CHECK_EN
      expDisp = !(ones == 4 || ones == 5 || ones == 6) ||
                (ones == 6 && rdPos) || (ones == 4 && !rdPos);
      if (ones == 6) rdPos = 1'b1;
      if (ones == 4) rdPos = 1'b0;
`else
      expDisp = 1'b0;
`endif
   endtask

   // Advance the transaction model across one rising edge
   task automatic modelEdge(input logic v, input sym10_t s, input logic r);
      bit xfer;
      bit had;
      if (r) begin
         curBits.delete();
         waitQ.delete();
         expUnderrun = 1'b0;
         expDisp     = 1'b0;
         rdPos       = 1'b0;
         return;
      end
      xfer        = v && (waitQ.size() == 0);
      had         = curBits.size() > 0;
      expUnderrun = 1'b0;
      expDisp     = 1'b0;
      if (had) void'(curBits.pop_front());
      if (curBits.size() == 0) begin
         if (waitQ.size() > 0) loadSym(waitQ.pop_front());
         else if (xfer) loadSym(s);
         else if (had) expUnderrun = 1'b1;
      end else if (xfer) begin
         waitQ.push_back(s);
      end
   endtask

   // Compare every output against the model in the middle of the cycle
   task automatic checkAll();
      checkOutput("ser_valid", ser_valid_o, curBits.size() > 0);
      if (curBits.size() > 0) checkOutput("ser_bit", ser_o, curBits[0]);
      else                    checkOutput("ser_idle", ser_o, 0);
      checkOutput("sym_ready", sym_ready_o, waitQ.size() == 0);
      checkOutput("underrun", underrun_o, expUnderrun);
      checkOutput("disp_err", disp_err_o, expDisp);
   endtask

   // One cycle: drive at the falling edge, update model at the rising edge, check after
   task automatic applyStimulus(input logic v, input sym10_t s, input logic r);
      sym_valid_i = v;
      sym_i       = s;
      rst_i       = r;
      @(posedge clk_i);
      modelEdge(v, s, r);
      @(negedge clk_i);
      checkAll();
   endtask

   // Hold a symbol with valid high until the block takes it (bounded)
   task automatic sendHeld(input sym10_t s);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 25 && !done; i++) begin
         done = (waitQ.size() == 0);
         applyStimulus(1'b1, s, 1'b0);
      end
      checkOutput("send_accepted", done, 1);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, sym10_t'($urandom), 1'b0);
   endtask

   initial begin
      logic [9:0] cap;
      int         prob;
      @(negedge clk_i);

      // Reset values
      applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("rst_ready", sym_ready_o, 1);
      checkOutput("rst_valid", ser_valid_o, 0);

      // Single symbol: bit 'a' on the next cycle, underrun right after bit 'j'
      applyStimulus(1'b1, 10'h17C, 1'b0);
      cap[0] = ser_o;
      for (int i = 1; i < 10; i++) begin
         applyStimulus(1'b0, '0, 1'b0);
         cap[i] = ser_o;
      end
      checkOutput("single_bits", cap, 10'h17C);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("single_underrun", underrun_o, 1);
      idleCycles(3);

      // Gapless streaming of two symbols
      applyStimulus(1'b0, '0, 1'b1);
      sendHeld(10'h17C);
      sendHeld(10'h283);
      idleCycles(22);

      // Backpressure with three symbols held back-to-back
      sendHeld(10'h17C);
      sendHeld(10'h283);
      sendHeld(10'h2AA);
      idleCycles(24);

      // Reset while bit 4 is on the wire and the hold slot is full
      sendHeld(10'h155);
      sendHeld(10'h0F3);
      idleCycles(3);
      checkOutput("mid_hold_full", sym_ready_o, 0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("mid_rst_valid", ser_valid_o, 0);
      checkOutput("mid_rst_ready", sym_ready_o, 1);
      checkOutput("mid_rst_underrun", underrun_o, 0);
      idleCycles(3);

      // Disparity sequence from a fresh reset
      applyStimulus(1'b0, '0, 1'b1);
      sendHeld(10'h17C);
      sendHeld(10'h17C);
      sendHeld(10'h3FF);
      idleCycles(35);

      // Random traffic with varying load and occasional resets
      prob = 100;
      for (int c = 0; c < 4000; c++) begin
         if (c % 150 == 0) begin
            case ($urandom_range(0, 2))
               0:       prob = 20;
               1:       prob = 70;
               default: prob = 100;
            endcase
         end
         applyStimulus($urandom_range(0, 99) < prob, sym10_t'($urandom),
                       $urandom_range(0, 499) == 0);
      end
      idleCycles(25);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/tx_serializer_10b.md
TX_SERIALIZER_10B -- requirements
Module: tx_serializer_10b

Interface
REQ-001 Parameter: SYM_W, 10, encoded symbol width; the only legal value is 10.
REQ-002 clk_i  input  1  bit clock; one clock, all logic on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 sym_valid_i  input  1  an encoded symbol is offered on sym_i.
REQ-005 sym_i  input  10  8b/10b symbol {j,h,g,f,i,e,d,c,b,a}; sym_i[5:0]=6b sub-block, sym_i[9:6]=4b sub-block, bit 0 ('a') transmitted first.
REQ-006 sym_ready_o  output  1  block can take a symbol; driven directly from a flop.
REQ-007 ser_o  output  1  serial bit out.
REQ-008 ser_valid_o  output  1  ser_o carries a symbol bit this cycle.
REQ-009 underrun_o  output  1  one-cycle pulse: stream ran dry after a symbol.
REQ-010 disp_err_o  output  1  one-cycle pulse: loaded symbol violates disparity rules (REQ-026).

Function
REQ-011 The symbol transfer SHALL occur on a rising edge where sym_valid_i and sym_ready_o are both 1; sym_i is not sampled otherwise.
REQ-012 Storage SHALL be a 10-bit shift register plus a 10-bit holding register with a hold_valid flag; sym_ready_o = !hold_valid.
REQ-013 The FSM SHALL have states IDLE and SHIFT and a 4-bit bit counter counting 0..9.
REQ-014 IDLE: ser_o=0, ser_valid_o=0; on a transfer, load the shift register, clear the counter, go to SHIFT.
REQ-015 SHIFT: ser_o=shift[0], ser_valid_o=1; the shift register shifts right each cycle; the counter increments.
REQ-016 A transfer in SHIFT with counter<9 SHALL write the holding register and set hold_valid.
REQ-017 At counter==9 with hold_valid=1: load the shift register from hold, clear hold_valid, counter to 0, stay in SHIFT.
REQ-018 At counter==9 with hold_valid=0 and a transfer that cycle: load the shift register directly from sym_i and stay in SHIFT.
REQ-019 At counter==9 with no pending symbol: go to IDLE and assert underrun_o for exactly the first IDLE cycle.
REQ-020 Latency: the symbol transferred at edge N SHALL drive bit 'a' during cycle N+1 when the block was idle or gapless-streaming.
REQ-021 Symbols fed with sym_valid_i held high SHALL leave ser_o with no idle gap between them.
REQ-022 No symbol SHALL be dropped, duplicated or reordered under any backpressure pattern.

Reset
REQ-023 While rst_i=1 at an edge: state=IDLE, counter=0, shift and hold registers=0, hold_valid=0.
REQ-024 Output values after reset: ser_o=0, ser_valid_o=0, sym_ready_o=1, underrun_o=0, disp_err_o=0.
REQ-025 Reset asserted mid-symbol SHALL discard the partial symbol and any held symbol, with no underrun_o pulse.

Configuration
REQ-026 With TX_SER_DISP_CHECK_EN defined, each symbol entering the shift register SHALL be checked against a tracked running disparity.
  - Running disparity is negative after reset.
  - Legal: 5 ones at either RD; 6 ones only from RD- (RD becomes +); 4 ones only from RD+ (RD becomes -).
  - Any other ones count, or wrong RD, is illegal; disp_err_o pulses during the symbol's bit-'a' cycle.
  - RD is unchanged on an illegal count; on a wrong-RD symbol, RD follows the symbol's own disparity.
REQ-027 Without TX_SER_DISP_CHECK_EN: disp_err_o is tied 0 and no checker logic is present.

Structure
REQ-028 Package pcie_phy_pkg SHALL hold SYM_W=10, typedef sym10_t (logic [9:0]) and enum ser_state_e {SER_IDLE, SER_SHIFT}.
REQ-029 The checker SHALL be a sub-module, disparity_checker_10b, instantiated only under TX_SER_DISP_CHECK_EN.

Verification
REQ-030 Single symbol: reset, transfer 10'h17C at edge N -> ser_o over cycles N+1..N+10 = 0,0,1,1,1,1,1,0,1,0 with ser_valid_o=1; underrun_o=1 only in cycle N+11.
REQ-031 Gapless streaming: sym_valid_i held with 10'h17C then 10'h283 -> 20 contiguous ser_valid_o cycles; second ser_o sequence 1,1,0,0,0,0,0,1,0,1; one underrun_o pulse after them; disp_err_o=0.
REQ-032 Backpressure: sym_valid_i held with 3 distinct symbols -> sym_ready_o low while hold is full; all 30 bits emitted in order.
REQ-033 Reset mid-symbol: assert rst_i while bit 4 is on ser_o, with hold full -> next cycle ser_valid_o=0, sym_ready_o=1, underrun_o=0.
REQ-034 Checker, macro defined: send 10'h17C, 10'h17C, 10'h3FF -> disp_err_o pulses on the 2nd and 3rd symbols only.
REQ-035 Checker, macro undefined: same stimulus as REQ-034 -> disp_err_o stays 0.
